dmem_access_unit: RTL and testbench
===================================

// Module: dmem_access_unit
// PURPOSE
// - MEM-stage load/store unit: consumes decoded memory controls (read/write, byte-lane size mask, unsigned flag)
//   plus EX-stage address/store data; drives a single-outstanding req/gnt/rvalid data-memory bus.
// - Aligns store data and byte enables; extracts, zero-extends or sign-extends load data for writeback.
// - Stalls the pipeline while an access is in flight and flags misaligned or illegal-size accesses.
// PARAMETERS
// - ADDR_WIDTH  32  byte address width on the bus
// - XLEN        32  data width; only 32 is supported
// PORTS
// - i_clk           in   1           core clock
// - i_rst_n         in   1           asynchronous, active-low reset
// - i_mem_read      in   1           load in MEM stage
// - i_mem_write     in   1           store in MEM stage
// - i_d_size        in   4           lane mask: 0001 byte, 0011 half, 1111 word
// - i_d_unsigned    in   1           zero-extend the load (LBU/LHU)
// - i_addr          in   ADDR_WIDTH  effective byte address
// - i_wdata         in   XLEN        store data, LSB-justified
// - o_rdata         out  XLEN        extended load result; valid while o_stall=0 in DONE
// - o_stall         out  1           hold the pipeline
// - o_misaligned    out  1           address/size exception for the current access
// - o_dmem_req      out  1           bus request
// - o_dmem_we       out  1           1 = write
// - o_dmem_be       out  4           byte enables
// - o_dmem_addr     out  ADDR_WIDTH  word-aligned address ({addr[AW-1:2],2'b00})
// - o_dmem_wdata    out  XLEN        lane-shifted store data
// - i_dmem_gnt      in   1           request accepted this cycle
// - i_dmem_rvalid   in   1           read data valid
// - i_dmem_rdata    in   XLEN        raw word read data
// BEHAVIOUR
// - Reset: state IDLE; o_rdata=0; all bus outputs, o_stall and o_misaligned = 0; latched request regs = 0.
// - Access = i_mem_read | i_mem_write. Both asserted: treated as a store.
// - Misaligned: size 0011 with addr[0]=1; size 1111 with addr[1:0]!=0; any other size mask is illegal.
//   Either condition: o_misaligned=1 combinationally in IDLE, no bus request, o_stall=0.
// - be = i_d_size << addr[1:0]; wdata = i_wdata << (8*addr[1:0]).
// - FSM (one outstanding access):
//   - IDLE: a legal access drives o_dmem_req=1 combinationally from the inputs, and o_stall=1.
//     It latches we, be, addr, wdata, offset, size and unsigned.
//     - gnt & store -> DONE.
//     - gnt & load -> WAIT.
//     - no gnt -> REQ.
//   - REQ: re-drive the latched request with req=1 (outputs stable until gnt); o_stall=1.
//     - gnt -> WAIT for a load, DONE for a store.
//   - WAIT: req=0, o_stall=1.
//     - rvalid -> capture aligned/extended data into o_rdata, go to DONE.
//     - rvalid in the same cycle as gnt is not legal bus behaviour; it is ignored in IDLE/REQ.
//   - DONE: o_stall=0 for exactly one cycle so the pipeline advances; no new request this cycle; -> IDLE.
// - Load latency with gnt in the same cycle and rvalid one cycle later: 3 cycles (IDLE, WAIT, DONE).
// - Store latency with immediate gnt: 2 cycles.
// - Load extract: s = rdata >> (8*offset).
//   - byte: {24{~uns & s[7]}, s[7:0]}
//   - half: {16{~uns & s[15]}, s[15:0]}
//   - word: s
// - o_rdata holds its value outside DONE until the next captured load.
// - Reset asserted mid-access: immediate return to IDLE, req dropped, stall cleared; a late rvalid after reset is ignored in IDLE.
// STRUCTURE
// - Shared package dmem_pkg:
//   - size constants DSIZE_BYTE=4'b0001, DSIZE_HALF=4'b0011, DSIZE_WORD=4'b1111
//   - typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} dmem_state_e
// - Sub-module load_align_ext (combinational): offset, size, unsigned flag and raw word in; extended XLEN out.
// - Store alignment and the FSM stay inline in this module.
// TESTING
// - LW addr 0x100, gnt same cycle, rvalid +1 with rdata 0xDEADBEEF -> be=1111, stall 2 cycles, o_rdata=0xDEADBEEF in DONE.
// - LB addr 0x103, rdata 0x80FF_0000 -> be=1000, o_rdata=0xFFFFFF80. Same access as LBU -> 0x00000080.
// - SH addr 0x202, wdata 0x0000_1234, gnt delayed 3 cycles -> req/we/be=1100/wdata=0x1234_0000 stable through REQ; DONE follows gnt.
// - LW addr 0x101 -> o_misaligned=1, o_dmem_req never asserted, o_stall=0.
// - LH addr 0x10E, gnt same cycle, rvalid +4 with rdata 0xFFFF_0000 -> stall 5 cycles, o_rdata=0xFFFFFFFF.
// - i_rst_n low while in WAIT, then rvalid pulses in IDLE -> outputs at reset values, o_rdata stays 0, no DONE.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: size lane masks,
// FSM state encoding and the alignment legality check.
package dmem_pkg;

    localparam logic [3:0] DSIZE_BYTE = 4'b0001;
    localparam logic [3:0] DSIZE_HALF = 4'b0011;
    localparam logic [3:0] DSIZE_WORD = 4'b1111;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} dmem_state_e;

    // Legal when the size mask is known and the address is naturally aligned to it.
    function automatic logic access_legal(input logic [3:0] size, input logic [1:0] off);
        case (size)
            DSIZE_BYTE: access_legal = 1'b1;
            DSIZE_HALF: access_legal = ~off[0];
            DSIZE_WORD: access_legal = (off == 2'b00);
            default:    access_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Shifts the raw bus word down to the addressed lane and zero/sign-extends
// it to XLEN according to the access size.
module load_align_ext
    import dmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      i_offset,
    input  logic [3:0]      i_size,
    input  logic            i_unsigned,
    input  logic [XLEN-1:0] i_raw,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = i_raw >> {i_offset, 3'b000};
        case (i_size)
            DSIZE_BYTE: o_data = {{(XLEN-8){~i_unsigned & shifted[7]}}, shifted[7:0]};
            DSIZE_HALF: o_data = {{(XLEN-16){~i_unsigned & shifted[15]}}, shifted[15:0]};
            default:    o_data = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store unit driving a single-outstanding req/gnt/rvalid bus;
// stalls the pipeline while an access is in flight.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int XLEN       = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [3:0]            i_d_size,
    input  logic                  i_d_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [XLEN-1:0]       i_wdata,
    output logic [XLEN-1:0]       o_rdata,
    output logic                  o_stall,
    output logic                  o_misaligned,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [3:0]            o_dmem_be,
    output logic [ADDR_WIDTH-1:0] o_dmem_addr,
    output logic [XLEN-1:0]       o_dmem_wdata,
    input  logic                  i_dmem_gnt,
    input  logic                  i_dmem_rvalid,
    input  logic [XLEN-1:0]       i_dmem_rdata
);

    dmem_state_e           state_q, state_d;
    logic                  we_q, we_d;
    logic [3:0]            be_q, be_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [1:0]            off_q, off_d;
    logic [3:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [XLEN-1:0]       rdata_q, rdata_d;

    logic                  access, legal, issue;
    logic [1:0]            in_off;
    logic [3:0]            in_be;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [XLEN-1:0]       in_wdata;
    logic [XLEN-1:0]       load_ext;

    load_align_ext #(.XLEN(XLEN)) u_load_align_ext (
        .i_offset   (off_q),
        .i_size     (size_q),
        .i_unsigned (uns_q),
        .i_raw      (i_dmem_rdata),
        .o_data     (load_ext)
    );

    always_comb begin
        in_off   = i_addr[1:0];
        in_be    = i_d_size << in_off;
        in_addr  = {i_addr[ADDR_WIDTH-1:2], 2'b00};
        in_wdata = i_wdata << {in_off, 3'b000};
        access   = i_mem_read | i_mem_write;
        legal    = access_legal(i_d_size, in_off);
        issue    = (state_q == IDLE) && access && legal;

        state_d = state_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;

        o_misaligned = (state_q == IDLE) && access && !legal;
        o_stall      = 1'b0;
        o_dmem_req   = 1'b0;
        o_dmem_we    = 1'b0;
        o_dmem_be    = 4'b0000;
        o_dmem_addr  = '0;
        o_dmem_wdata = '0;

        // rvalid outside WAIT is never acted on, which also covers a late
        // response arriving after a mid-access reset.
        case (state_q)
            IDLE: begin
                if (issue) begin
                    o_stall      = 1'b1;
                    o_dmem_req   = 1'b1;
                    o_dmem_we    = i_mem_write;
                    o_dmem_be    = in_be;
                    o_dmem_addr  = in_addr;
                    o_dmem_wdata = in_wdata;
                    we_d    = i_mem_write;
                    be_d    = in_be;
                    addr_d  = in_addr;
                    wdata_d = in_wdata;
                    off_d   = in_off;
                    size_d  = i_d_size;
                    uns_d   = i_d_unsigned;
                    if (i_dmem_gnt) state_d = i_mem_write ? DONE : WAIT;
                    else            state_d = REQ;
                end
            end
            REQ: begin
                o_stall      = 1'b1;
                o_dmem_req   = 1'b1;
                o_dmem_we    = we_q;
                o_dmem_be    = be_q;
                o_dmem_addr  = addr_q;
                o_dmem_wdata = wdata_q;
                if (i_dmem_gnt) state_d = we_q ? DONE : WAIT;
            end
            WAIT: begin
                o_stall = 1'b1;
                if (i_dmem_rvalid) begin
                    rdata_d = load_ext;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: loads, stores, misaligned accesses,
// delayed grant/response and reset in the middle of a load.
module tb_dmem_access_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_mem_read, i_mem_write;
    logic [3:0]  i_d_size;
    logic        i_d_unsigned;
    logic [31:0] i_addr, i_wdata;
    logic [31:0] o_rdata;
    logic        o_stall, o_misaligned;
    logic        o_dmem_req, o_dmem_we;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic        i_dmem_gnt, i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    dmem_access_unit #(.ADDR_WIDTH(32), .XLEN(32)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_d_size     (i_d_size),
        .i_d_unsigned (i_d_unsigned),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_rdata      (o_rdata),
        .o_stall      (o_stall),
        .o_misaligned (o_misaligned),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_be    (o_dmem_be),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_wdata (o_dmem_wdata),
        .i_dmem_gnt   (i_dmem_gnt),
        .i_dmem_rvalid(i_dmem_rvalid),
        .i_dmem_rdata (i_dmem_rdata)
    );

    // Observations from one access, filled in by run_access.
    int          ob_stalls;
    bit          ob_done, ob_req_seen, ob_stable, ob_mis, ob_we;
    logic [3:0]  ob_be;
    logic [31:0] ob_addr, ob_wdata, ob_rdata;

    task automatic idle_inputs();
        i_mem_read = 0; i_mem_write = 0; i_d_size = 4'b0000; i_d_unsigned = 0;
        i_addr = 0; i_wdata = 0; i_dmem_gnt = 0; i_dmem_rvalid = 0; i_dmem_rdata = 0;
    endtask

    // Presents one access and plays the bus: gnt after gdly request cycles,
    // rvalid rdly cycles after the gnt cycle. Stops at the first unstalled cycle.
    task automatic run_access(input bit rd, input bit wr, input logic [3:0] size,
                              input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                              input int gdly, input int rdly, input logic [31:0] rdat);
        int reqc, gcyc;
        reqc = 0; gcyc = -1;
        ob_stalls = 0; ob_done = 0; ob_req_seen = 0; ob_stable = 1; ob_mis = 0;
        ob_we = 0; ob_be = 0; ob_addr = 0; ob_wdata = 0; ob_rdata = 0;
        @(posedge i_clk); #1;
        i_mem_read = rd; i_mem_write = wr; i_d_size = size; i_d_unsigned = uns;
        i_addr = addr; i_wdata = wd;
        for (int cyc = 0; cyc < 50; cyc++) begin
            i_dmem_gnt = 0; i_dmem_rvalid = 0; i_dmem_rdata = 0;
            #1;
            if (o_misaligned) ob_mis = 1;
            if (!o_stall) begin
                ob_done = 1; ob_rdata = o_rdata;
                break;
            end
            ob_stalls++;
            if (o_dmem_req) begin
                if (!ob_req_seen) begin
                    ob_req_seen = 1; ob_we = o_dmem_we; ob_be = o_dmem_be;
                    ob_addr = o_dmem_addr; ob_wdata = o_dmem_wdata;
                end else if (o_dmem_we !== ob_we || o_dmem_be !== ob_be ||
                             o_dmem_addr !== ob_addr || o_dmem_wdata !== ob_wdata) begin
                    ob_stable = 0;
                end
                if (reqc == gdly) begin i_dmem_gnt = 1; gcyc = cyc; end
                reqc++;
            end
            if (gcyc >= 0 && cyc == gcyc + rdly) begin
                i_dmem_rvalid = 1; i_dmem_rdata = rdat;
            end
            @(posedge i_clk); #1;
        end
        idle_inputs();
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rst_n = 0;
        #12;
        total++; if (o_dmem_req !== 1'b0)   begin bad++; $display("FAIL reset_req got=%b exp=0", o_dmem_req); end
        total++; if (o_stall !== 1'b0)      begin bad++; $display("FAIL reset_stall got=%b exp=0", o_stall); end
        total++; if (o_rdata !== 32'h0)     begin bad++; $display("FAIL reset_rdata got=%h exp=0", o_rdata); end
        total++; if (o_misaligned !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b exp=0", o_misaligned); end
        total++; if ({o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata} !== 69'h0)
            begin bad++; $display("FAIL reset_bus got we=%b be=%b addr=%h wd=%h exp=0", o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata); end
        @(negedge i_clk); i_rst_n = 1;
    endtask

    task automatic test_lw();
        run_access(1, 0, 4'b1111, 0, 32'h100, 0, 0, 1, 32'hDEADBEEF);
        total++; if (!ob_done)               begin bad++; $display("FAIL lw_timeout"); end
        total++; if (ob_be !== 4'b1111 || ob_we !== 0 || ob_addr !== 32'h100)
            begin bad++; $display("FAIL lw_bus got be=%b we=%b addr=%h exp be=1111 we=0 addr=100", ob_be, ob_we, ob_addr); end
        total++; if (ob_stalls != 2)         begin bad++; $display("FAIL lw_stalls got=%0d exp=2", ob_stalls); end
        total++; if (ob_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", ob_rdata); end
    endtask

    task automatic test_lb_lbu();
        run_access(1, 0, 4'b0001, 0, 32'h103, 0, 0, 1, 32'h80FF_0000);
        total++; if (ob_be !== 4'b1000 || ob_addr !== 32'h100)
            begin bad++; $display("FAIL lb_bus got be=%b addr=%h exp be=1000 addr=100", ob_be, ob_addr); end
        total++; if (ob_rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_rdata got=%h exp=ffffff80", ob_rdata); end
        run_access(1, 0, 4'b0001, 1, 32'h103, 0, 0, 1, 32'h80FF_0000);
        total++; if (ob_rdata !== 32'h00000080) begin bad++; $display("FAIL lbu_rdata got=%h exp=00000080", ob_rdata); end
        // Bytes outside the addressed lane must not leak in.
        run_access(1, 0, 4'b0011, 1, 32'h102, 0, 0, 1, 32'h8001_7FFF);
        total++; if (ob_rdata !== 32'h00008001) begin bad++; $display("FAIL lhu_rdata got=%h exp=00008001", ob_rdata); end
    endtask

    task automatic test_sh_delayed_gnt();
        run_access(0, 1, 4'b0011, 0, 32'h202, 32'h0000_1234, 3, 0, 0);
        total++; if (!ob_done)                   begin bad++; $display("FAIL sh_timeout"); end
        total++; if (ob_we !== 1 || ob_be !== 4'b1100 || ob_addr !== 32'h200)
            begin bad++; $display("FAIL sh_bus got we=%b be=%b addr=%h exp we=1 be=1100 addr=200", ob_we, ob_be, ob_addr); end
        total++; if (ob_wdata !== 32'h1234_0000) begin bad++; $display("FAIL sh_wdata got=%h exp=12340000", ob_wdata); end
        total++; if (!ob_stable)                 begin bad++; $display("FAIL sh_stable got=0 exp=1"); end
        total++; if (ob_stalls != 4)             begin bad++; $display("FAIL sh_stalls got=%0d exp=4", ob_stalls); end
        // Read and write together is a store; immediate gnt gives one stall cycle.
        run_access(1, 1, 4'b0001, 0, 32'h301, 32'h0000_00AB, 0, 0, 0);
        total++; if (ob_we !== 1 || ob_be !== 4'b0010 || ob_wdata !== 32'h0000_AB00 || ob_stalls != 1)
            begin bad++; $display("FAIL sb_both got we=%b be=%b wd=%h st=%0d exp we=1 be=0010 wd=0000ab00 st=1", ob_we, ob_be, ob_wdata, ob_stalls); end
    endtask

    task automatic test_misaligned();
        logic [3:0]  sz [3];
        logic [31:0] ad [3];
        sz[0] = 4'b1111; ad[0] = 32'h101;
        sz[1] = 4'b0011; ad[1] = 32'h103;
        sz[2] = 4'b0111; ad[2] = 32'h100;
        for (int k = 0; k < 3; k++) begin
            run_access(1, 0, sz[k], 0, ad[k], 0, 0, 1, 32'h1);
            total++;
            if (!ob_mis || ob_req_seen || ob_stalls != 0)
                begin bad++; $display("FAIL misaligned_%0d got mis=%b req=%b st=%0d exp mis=1 req=0 st=0", k, ob_mis, ob_req_seen, ob_stalls); end
        end
        total++; if (o_rdata !== 32'h00008001) begin bad++; $display("FAIL mis_rdata_hold got=%h exp=00008001", o_rdata); end
    endtask

    task automatic test_lh_slow_rvalid();
        run_access(1, 0, 4'b0011, 0, 32'h10E, 0, 0, 4, 32'hFFFF_0000);
        total++; if (ob_be !== 4'b1100 || ob_addr !== 32'h10C)
            begin bad++; $display("FAIL lh_bus got be=%b addr=%h exp be=1100 addr=10c", ob_be, ob_addr); end
        total++; if (ob_stalls != 5)            begin bad++; $display("FAIL lh_stalls got=%0d exp=5", ob_stalls); end
        total++; if (ob_rdata !== 32'hFFFFFFFF) begin bad++; $display("FAIL lh_rdata got=%h exp=ffffffff", ob_rdata); end
    endtask

    task automatic test_reset_in_wait();
        @(posedge i_clk); #1;
        i_mem_read = 1; i_d_size = 4'b1111; i_addr = 32'h400; i_dmem_gnt = 1;
        @(posedge i_clk); #1;
        idle_inputs();
        total++; if (o_stall !== 1'b1 || o_dmem_req !== 1'b0)
            begin bad++; $display("FAIL rw_wait got stall=%b req=%b exp stall=1 req=0", o_stall, o_dmem_req); end
        i_rst_n = 0;
        #1;
        total++; if (o_stall !== 0 || o_dmem_req !== 0 || o_rdata !== 32'h0)
            begin bad++; $display("FAIL rw_reset got stall=%b req=%b rdata=%h exp 0/0/0", o_stall, o_dmem_req, o_rdata); end
        @(negedge i_clk); i_rst_n = 1;
        @(posedge i_clk); #1;
        i_dmem_rvalid = 1; i_dmem_rdata = 32'h1234_5678;
        @(posedge i_clk); #1;
        i_dmem_rvalid = 0;
        @(posedge i_clk); #1;
        total++; if (o_rdata !== 32'h0 || o_stall !== 0 || o_dmem_req !== 0)
            begin bad++; $display("FAIL rw_late_rvalid got rdata=%h stall=%b req=%b exp 0/0/0", o_rdata, o_stall, o_dmem_req); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh_delayed_gnt();
        test_misaligned();
        test_lh_slow_rvalid();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
